// File: rtl/security_zone_fsm_pkg.sv
// Shared definitions for the multi-zone security controller.
// Contents: state encodings, the hex-to-7-segment glyph table, the blank
// glyph, width derivations for the timers and zone index, and a
// lowest-set-bit helper used to pick the tripped zone.
package security_zone_fsm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } state_e;

    // Zone index width covers the largest legal zone count (8).
    localparam int ZONE_W = $clog2(8);
    // Seconds counter width; every delay parameter is at most 255.
    localparam int SEC_W  = 8;

    localparam logic [6:0] BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Counter width able to hold 0..cycles-1 (never less than 1 bit).
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [ZONE_W-1:0] lowest_set(input logic [7:0] v);
        logic [ZONE_W-1:0] idx;
        idx = ZONE_W'(0);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = ZONE_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/security_zone_fsm_seg7_decoder.sv
// Combinational 4-bit value to 7-segment glyph lookup with blank enable.
// Ports: value - hex digit to show; blank - 1 forces all segments off;
//        seg   - {g,f,e,d,c,b,a}, active-high.
module security_zone_fsm_seg7_decoder
    import security_zone_fsm_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup, overridden by blank.
    always_comb begin
        seg = BLANK;
        if (blank) begin
            seg = BLANK;
        end else begin
            seg = SEG_TABLE[value];
        end
    end

endmodule

// File: rtl/security_zone_fsm.sv
// Multi-zone alarm controller with per-zone bypass, instant/delayed zones,
// exit and entry delays, siren auto-silence, alarm memory and a two-digit
// multiplexed 7-segment status display.
// Ports: CLK clock; RST synchronous active-low reset; KEY arm (2'b11) or
//        disarm; SENSOR raw zone inputs; ZONE_EN zone monitor enables;
//        ALARM siren; STATE state code; MEMORY alarm since last arm;
//        TRIP_ZONE zone of last alarm; AN segments; CA digit select
//        (1 = left/state, 0 = right/zone).
module security_zone_fsm
    import security_zone_fsm_pkg::*;
#(
    parameter int                    CLK_FREQ        = 125_000_000,
    parameter int                    NUM_ZONES       = 4,
    parameter logic [NUM_ZONES-1:0]  INSTANT_MASK    = 4'b0010,
    parameter int                    ENTRY_DELAY_S   = 5,
    parameter int                    EXIT_DELAY_S    = 3,
    parameter int                    ALARM_TIMEOUT_S = 30,
    parameter int                    REFRESH_DIV     = 62_500
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [1:0]           KEY,
    input  logic [NUM_ZONES-1:0] SENSOR,
    input  logic [NUM_ZONES-1:0] ZONE_EN,
    output logic                 ALARM,
    output logic [2:0]           STATE,
    output logic                 MEMORY,
    output logic [2:0]           TRIP_ZONE,
    output logic [6:0]           AN,
    output logic                 CA
);

    localparam int TIMER_W = timer_width(CLK_FREQ);
    localparam int DIV_W   = timer_width(REFRESH_DIV);
    localparam logic [TIMER_W-1:0] PRE_LAST   = TIMER_W'(CLK_FREQ - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    // Last seconds value of each timed state; the exit value is unused
    // when the exit delay is 0 because EXIT_DELAY is then never entered.
    localparam logic [SEC_W-1:0]   EXIT_LAST  = SEC_W'(EXIT_DELAY_S - 1);
    localparam logic [SEC_W-1:0]   ENTRY_LAST = SEC_W'(ENTRY_DELAY_S - 1);
    localparam logic [SEC_W-1:0]   ALARM_LAST = SEC_W'(ALARM_TIMEOUT_S - 1);

    logic [1:0]           key_s1_q, key_s2_q;
    logic [NUM_ZONES-1:0] sensor_s1_q, sensor_s2_q;
    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   pre_q, pre_d;
    logic [SEC_W-1:0]     sec_q, sec_d;
    logic                 memory_q, memory_d;
    logic [ZONE_W-1:0]    trip_q, trip_d;
    logic                 alarm_q, alarm_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 ca_q, ca_d;
    logic [6:0]           an_q, an_d;

    logic [7:0]           eff_s, inst_s;
    logic [SEC_W-1:0]     delay_last_s;
    logic                 timer_done_s;
    logic [3:0]           digit_s;
    logic                 blank_s;
    logic [6:0]           seg_s;

    // Active zones after bypass, widened to the helper's 8-bit argument.
    always_comb begin
        eff_s  = 8'(sensor_s2_q & ZONE_EN);
        inst_s = eff_s & 8'(INSTANT_MASK);
    end

    // Timer expiry: last cycle of the last second of the current delay.
    always_comb begin
        delay_last_s = 8'd0;
        case (state_q)
            ST_EXIT_DELAY:  delay_last_s = EXIT_LAST;
            ST_ENTRY_DELAY: delay_last_s = ENTRY_LAST;
            ST_ALARM:       delay_last_s = ALARM_LAST;
            default:        delay_last_s = 8'd0;
        endcase
        timer_done_s = (pre_q == PRE_LAST) && (sec_q == delay_last_s);
    end

    // Next-state, alarm memory and trip-zone logic; disarm wins over all.
    always_comb begin
        state_d  = state_q;
        memory_d = memory_q;
        trip_d   = trip_q;
        if (key_s2_q != 2'b11) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    state_d  = (EXIT_DELAY_S == 0) ? ST_ARMED : ST_EXIT_DELAY;
                    memory_d = 1'b0;
                    trip_d   = ZONE_W'(0);
                end
                ST_EXIT_DELAY: begin
                    if (timer_done_s) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_EXIT_DELAY;
                    end
                end
                ST_ARMED: begin
                    if (inst_s != 8'd0) begin
                        state_d  = ST_ALARM;
                        memory_d = 1'b1;
                        trip_d   = lowest_set(inst_s);
                    end else if (eff_s != 8'd0) begin
                        state_d = ST_ENTRY_DELAY;
                        trip_d  = lowest_set(eff_s);
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ENTRY_DELAY: begin
                    // Releasing the sensor does not cancel the delay.
                    if (inst_s != 8'd0) begin
                        state_d  = ST_ALARM;
                        memory_d = 1'b1;
                        trip_d   = lowest_set(inst_s);
                    end else if (timer_done_s) begin
                        state_d  = ST_ALARM;
                        memory_d = 1'b1;
                    end else begin
                        state_d = ST_ENTRY_DELAY;
                    end
                end
                ST_ALARM: begin
                    if (timer_done_s) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_ALARM;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end
        // Registered siren tracks the state being entered, so it has no
        // extra latency relative to STATE.
        alarm_d = (state_d == ST_ALARM);
    end

    // Shared prescaler and seconds counter; cleared on any state change.
    always_comb begin
        pre_d = TIMER_W'(0);
        sec_d = SEC_W'(0);
        if (state_d != state_q) begin
            pre_d = TIMER_W'(0);
            sec_d = SEC_W'(0);
        end else if (state_q == ST_EXIT_DELAY || state_q == ST_ENTRY_DELAY ||
                     state_q == ST_ALARM) begin
            if (pre_q == PRE_LAST) begin
                pre_d = TIMER_W'(0);
                sec_d = sec_q + SEC_W'(1);
            end else begin
                pre_d = pre_q + TIMER_W'(1);
                sec_d = sec_q;
            end
        end else begin
            pre_d = TIMER_W'(0);
            sec_d = SEC_W'(0);
        end
    end

    // Digit slot timing; AN is reloaded with the new digit as CA toggles.
    always_comb begin
        div_d = div_q;
        ca_d  = ca_q;
        an_d  = an_q;
        if (div_q == DIV_LAST) begin
            div_d = DIV_W'(0);
            ca_d  = ~ca_q;
            an_d  = seg_s;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Digit source mux keyed on the upcoming CA value.
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b0;
        if (ca_d) begin
            digit_s = {1'b0, state_q};
            blank_s = 1'b0;
        end else begin
            digit_s = {1'b0, trip_q} + 4'd1;
            blank_s = ~memory_q;
        end
    end

    security_zone_fsm_seg7_decoder u_seg7 (
        .value (digit_s),
        .blank (blank_s),
        .seg   (seg_s)
    );

    // Two-flop synchronisers for the asynchronous key and sensor inputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            key_s1_q    <= 2'b00;
            key_s2_q    <= 2'b00;
            sensor_s1_q <= '0;
            sensor_s2_q <= '0;
        end else begin
            key_s1_q    <= KEY;
            key_s2_q    <= key_s1_q;
            sensor_s1_q <= SENSOR;
            sensor_s2_q <= sensor_s1_q;
        end
    end

    // FSM, timer and alarm bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_DISARMED;
            pre_q    <= TIMER_W'(0);
            sec_q    <= SEC_W'(0);
            memory_q <= 1'b0;
            trip_q   <= ZONE_W'(0);
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            sec_q    <= sec_d;
            memory_q <= memory_d;
            trip_q   <= trip_d;
            alarm_q  <= alarm_d;
        end
    end

    // Display multiplexer registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            div_q <= DIV_W'(0);
            ca_q  <= 1'b0;
            an_q  <= BLANK;
        end else begin
            div_q <= div_d;
            ca_q  <= ca_d;
            an_q  <= an_d;
        end
    end

    assign ALARM     = alarm_q;
    assign STATE     = state_q;
    assign MEMORY    = memory_q;
    assign TRIP_ZONE = trip_q;
    assign AN        = an_q;
    assign CA        = ca_q;

endmodule

// File: tb/tb_security_zone_fsm.sv
// Self-checking bench for security_zone_fsm. A cycle-level reference model
// predicts every output for each driven input vector and queues the
// prediction; the next sample pops and compares it. Directed checks on
// state durations, trip zones and display glyphs run alongside.
module tb_security_zone_fsm;

    localparam int F       = 10;
    localparam int EXIT_C  = 3 * F;
    localparam int ENTRY_C = 5 * F;
    localparam int ALARM_C = 10 * F;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] KEY = 2'b00;
    logic [3:0] SENSOR = 4'b0000;
    logic [3:0] ZONE_EN = 4'b1111;
    logic       ALARM;
    logic [2:0] STATE;
    logic       MEMORY;
    logic [2:0] TRIP_ZONE;
    logic [6:0] AN;
    logic       CA;

    security_zone_fsm #(
        .CLK_FREQ        (F),
        .NUM_ZONES       (4),
        .INSTANT_MASK    (4'b0010),
        .ENTRY_DELAY_S   (5),
        .EXIT_DELAY_S    (3),
        .ALARM_TIMEOUT_S (10),
        .REFRESH_DIV     (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .KEY       (KEY),
        .SENSOR    (SENSOR),
        .ZONE_EN   (ZONE_EN),
        .ALARM     (ALARM),
        .STATE     (STATE),
        .MEMORY    (MEMORY),
        .TRIP_ZONE (TRIP_ZONE),
        .AN        (AN),
        .CA        (CA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] state;
        logic       alarm;
        logic       mem;
        logic [2:0] trip;
        logic [6:0] an;
        logic       ca;
    } exp_t;

    exp_t sb_q[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic alarm_seen = 1'b0;

    logic       drv_rst = 1'b0;
    logic [1:0] drv_key = 2'b00;
    logic [3:0] drv_sensor = 4'b0000;
    logic [3:0] drv_zen = 4'b1111;

    // Reference model state.
    logic [1:0] m_k1 = 2'b00, m_k2 = 2'b00;
    logic [3:0] m_s1 = 4'b0000, m_s2 = 4'b0000;
    int         m_state = 0, m_cnt = 0, m_div = 0;
    logic       m_mem = 1'b0, m_alarm = 1'b0, m_ca = 1'b0;
    logic [2:0] m_trip = 3'd0;
    logic [6:0] m_an = 7'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [2:0] low_idx(input logic [3:0] v);
        casez (v)
            4'b???1: return 3'd0;
            4'b??10: return 3'd1;
            4'b?100: return 3'd2;
            default: return 3'd3;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic [1:0] key,
                              input logic [3:0] sen, input logic [3:0] zen);
        int ns;
        logic nm;
        logic [2:0] nt;
        logic [3:0] eff, inst;
        if (!rst) begin
            m_k1 = 2'b00; m_k2 = 2'b00; m_s1 = 4'b0000; m_s2 = 4'b0000;
            m_state = 0; m_cnt = 0; m_div = 0; m_mem = 1'b0; m_alarm = 1'b0;
            m_ca = 1'b0; m_trip = 3'd0; m_an = 7'h00;
        end else begin
            ns = m_state; nm = m_mem; nt = m_trip;
            eff = m_s2 & zen;
            inst = eff & 4'b0010;
            if (m_k2 != 2'b11) begin
                ns = 0;
            end else begin
                case (m_state)
                    0: begin ns = 1; nm = 1'b0; nt = 3'd0; end
                    1: if (m_cnt == EXIT_C - 1) ns = 2;
                    2: if (inst != 0) begin
                           ns = 4; nt = low_idx(inst); nm = 1'b1;
                       end else if (eff != 0) begin
                           ns = 3; nt = low_idx(eff);
                       end
                    3: if (inst != 0) begin
                           ns = 4; nt = low_idx(inst); nm = 1'b1;
                       end else if (m_cnt == ENTRY_C - 1) begin
                           ns = 4; nm = 1'b1;
                       end
                    4: if (m_cnt == ALARM_C - 1) ns = 2;
                    default: ns = 0;
                endcase
            end
            if (m_div == 1) begin
                m_div = 0;
                m_ca = ~m_ca;
                m_an = m_ca ? glyph(m_state) : (m_mem ? glyph(int'(m_trip) + 1) : 7'h00);
            end else begin
                m_div++;
            end
            m_cnt = (ns != m_state) ? 0 : m_cnt + 1;
            m_state = ns; m_mem = nm; m_trip = nt; m_alarm = (ns == 4);
            m_k2 = m_k1; m_k1 = key; m_s2 = m_s1; m_s1 = sen;
        end
    endtask

    // One cycle: compare the prediction for the edge just passed, then
    // apply the pending stimulus and queue its predicted outcome.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_state", 32'(STATE), 32'(e.state));
            check_eq("sb_alarm", 32'(ALARM), 32'(e.alarm));
            check_eq("sb_memory", 32'(MEMORY), 32'(e.mem));
            check_eq("sb_trip", 32'(TRIP_ZONE), 32'(e.trip));
            check_eq("sb_an", 32'(AN), 32'(e.an));
            check_eq("sb_ca", 32'(CA), 32'(e.ca));
        end
        if (ALARM === 1'b1) alarm_seen = 1'b1;
        RST = drv_rst; KEY = drv_key; SENSOR = drv_sensor; ZONE_EN = drv_zen;
        model_step(drv_rst, drv_key, drv_sensor, drv_zen);
        e.state = 3'(m_state); e.alarm = m_alarm; e.mem = m_mem;
        e.trip = m_trip; e.an = m_an; e.ca = m_ca;
        sb_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
        int n;
        n = 0;
        while (STATE !== s && n < limit) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(STATE), 32'(s));
    endtask

    initial begin
        int t0, t1, t2, n;

        // 1. Reset with key off, then display alternation.
        drv_rst = 1'b0; drv_key = 2'b00;
        repeat (5) tick();
        check_eq("rst_state", 32'(STATE), 32'd0);
        check_eq("rst_alarm", 32'(ALARM), 32'd0);
        check_eq("rst_memory", 32'(MEMORY), 32'd0);
        drv_rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (CA) check_eq("an_left_idle", 32'(AN), 32'h3F);
            else    check_eq("an_right_idle", 32'(AN), 32'h00);
        end

        // 2. Arm: exit delay ignores sensors and lasts 30 cycles.
        drv_key = 2'b11;
        wait_state(3'd1, 10, "reach_exit");
        t0 = cyc;
        drv_sensor = 4'b0001;
        repeat (4) tick();
        drv_sensor = 4'b0000;
        check_eq("exit_ignores_sensor", 32'(STATE), 32'd1);
        wait_state(3'd2, 40, "reach_armed");
        check_eq("exit_len", 32'(cyc - t0), 32'(EXIT_C));

        // 3. Delayed zone trip, then disarm during entry delay.
        alarm_seen = 1'b0;
        drv_sensor = 4'b0001;
        wait_state(3'd3, 10, "reach_entry");
        check_eq("entry_trip0", 32'(TRIP_ZONE), 32'd0);
        repeat (20) tick();
        drv_key = 2'b00; drv_sensor = 4'b0000;
        wait_state(3'd0, 10, "disarm_entry");
        check_eq("disarm_no_alarm", 32'(alarm_seen), 32'd0);
        check_eq("disarm_memory", 32'(MEMORY), 32'd0);

        // 4. Re-arm, entry delay expiry, alarm timeout and memory display.
        drv_key = 2'b11;
        wait_state(3'd2, 60, "rearm");
        drv_sensor = 4'b0001;
        repeat (3) tick();
        drv_sensor = 4'b0000;
        wait_state(3'd3, 10, "reach_entry2");
        t0 = cyc;
        wait_state(3'd4, 60, "entry_to_alarm");
        t1 = cyc;
        check_eq("entry_len", 32'(t1 - t0), 32'(ENTRY_C));
        check_eq("alarm_on", 32'(ALARM), 32'd1);
        check_eq("alarm_trip", 32'(TRIP_ZONE), 32'd0);
        check_eq("alarm_memory", 32'(MEMORY), 32'd1);
        wait_state(3'd2, 120, "alarm_timeout");
        t2 = cyc;
        check_eq("alarm_len", 32'(t2 - t1), 32'(ALARM_C));
        check_eq("silenced", 32'(ALARM), 32'd0);
        check_eq("memory_held", 32'(MEMORY), 32'd1);
        repeat (3) tick();
        n = 0;
        while (CA !== 1'b0 && n < 6) begin
            tick();
            n++;
        end
        check_eq("an_zone1", 32'(AN), 32'h06);

        // 5. Bypassed zone ignored, then instant zone escalates entry delay.
        drv_zen = 4'b1011; drv_sensor = 4'b0101;
        wait_state(3'd3, 10, "reach_entry3");
        check_eq("bypass_trip", 32'(TRIP_ZONE), 32'd0);
        repeat (10) tick();
        drv_sensor = 4'b0111;
        wait_state(3'd4, 6, "instant_alarm");
        check_eq("instant_trip", 32'(TRIP_ZONE), 32'd1);
        check_eq("instant_alarm_on", 32'(ALARM), 32'd1);

        // 6. Reset while alarming.
        drv_rst = 1'b0;
        tick();
        drv_rst = 1'b1;
        tick();
        check_eq("mid_rst_state", 32'(STATE), 32'd0);
        check_eq("mid_rst_alarm", 32'(ALARM), 32'd0);
        check_eq("mid_rst_memory", 32'(MEMORY), 32'd0);
        check_eq("mid_rst_trip", 32'(TRIP_ZONE), 32'd0);
        check_eq("mid_rst_an", 32'(AN), 32'h00);
        drv_sensor = 4'b0000; drv_zen = 4'b1111;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
